// File: rtl/reg_file_sb.sv
// Multi-port register file with per-register load scoreboard and a lower-priority load writeback port.
// Optional REG_BYPASS_EN forwards same-cycle write data (and wr1 busy clear) onto the read ports.
module reg_file_sb #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 4,
    parameter  int RD_PORTS = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RD_PORTS*AW-1:0]    rd_addr,
    output logic [RD_PORTS*WIDTH-1:0] rd_data,
    output logic [RD_PORTS-1:0]       rd_busy,
    input  logic                      wr0_en,
    input  logic [AW-1:0]             wr0_addr,
    input  logic [WIDTH-1:0]          wr0_data,
    input  logic                      wr1_en,
    input  logic [AW-1:0]             wr1_addr,
    input  logic [WIDTH-1:0]          wr1_data,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_addr,
    output logic                      iss_stall,
    output logic                      wr_conflict
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_conflict_q;
    logic             wr_conflict_d;
    logic             iss_same_wr1;

    assign iss_stall    = iss_en && busy_q[iss_addr];
    assign iss_same_wr1 = iss_en && wr1_en && (iss_addr == wr1_addr);
    assign wr_conflict  = wr_conflict_q;

    // wr1 is applied first so that wr0 overwrites it on a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr1_en) begin
            regs_d[wr1_addr] = wr1_data;
        end
        if (wr0_en) begin
            regs_d[wr0_addr] = wr0_data;
        end
    end

    // A fresh issue on the register being cleared keeps it busy, even when that issue is stalled.
    always_comb begin
        busy_d = busy_q;
        if (wr1_en && !iss_same_wr1) begin
            busy_d[wr1_addr] = 1'b0;
        end
        if (iss_en && !iss_stall) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        wr_conflict_d = wr0_en && wr1_en && (wr0_addr == wr1_addr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            logic [AW-1:0] ra;
            ra = rd_addr[k*AW +: AW];
            rd_data[k*WIDTH +: WIDTH] = regs_q[ra];
            rd_busy[k]                = busy_q[ra];
`ifdef REG_BYPASS_EN
            if (wr0_en && (wr0_addr == ra)) begin
                rd_data[k*WIDTH +: WIDTH] = wr0_data;
            end else if (wr1_en && (wr1_addr == ra)) begin
                rd_data[k*WIDTH +: WIDTH] = wr1_data;
            end
            if (wr1_en && (wr1_addr == ra)) begin
                rd_busy[k] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-port CPU register file with a per-register busy scoreboard and a second, lower-priority write port for load writeback.
- Sits between decode, ALU writeback (port 0) and memory/load writeback (port 1).
- Issue logic marks a load's destination busy. The load writeback clears it.
- Reads report data and busy status per port, so decode can stall on RAW or WAW hazards.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of registers; a power of two, minimum 2.
- RD_PORTS, 2, number of independent read ports, 1..4.
- AW, $clog2(DEPTH), derived localparam; address width, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  RD_PORTS*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  RD_PORTS*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].
- rd_busy  out  RD_PORTS  scoreboard busy bit of the addressed register, per port.
- wr0_en  in  1  write port 0 enable (ALU, high priority).
- wr0_addr  in  AW  write port 0 address.
- wr0_data  in  WIDTH  write port 0 data.
- wr1_en  in  1  write port 1 enable (load writeback); also clears busy.
- wr1_addr  in  AW  write port 1 address.
- wr1_data  in  WIDTH  write port 1 data.
- iss_en  in  1  issue of a load: mark iss_addr busy.
- iss_addr  in  AW  destination register of the issued load.
- iss_stall  out  1  combinational: iss_en and iss_addr already busy (WAW).
- wr_conflict  out  1  registered: high for one cycle after a same-address dual write.

Behaviour:
- Reset (async, on rst rising, held while rst=1):
  - all registers = 0, all busy bits = 0, wr_conflict = 0.
  - Outputs: rd_data = 0 on all ports, rd_busy = 0, iss_stall = 0.
- Reads: combinational, zero latency; rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]].
- Writes: registered, one-cycle latency. Data written at edge N is visible on reads after edge N (no bypass, see optional feature).
- Dual write, different addresses: both written at the same edge.
- Dual write, same address: wr0 data wins and wr1 data is dropped. wr_conflict = 1 for exactly the next cycle. The busy bit is still cleared by wr1.
- Scoreboard per register:
  - IDLE -> BUSY on iss_en && !iss_stall.
  - BUSY -> IDLE on wr1_en to that address.
  - Same-edge issue and wr1 clear on the same address: set wins, so the register stays BUSY (new load issued).
  - iss_en while the register is BUSY: iss_stall = 1 and the busy bit is unchanged; the issuer must hold and retry.
  - wr0 to a busy register: data written, busy unaffected.
  - wr1 to a non-busy register: data written, busy stays 0, no error.
- Address width: addresses are exactly AW bits, so out-of-range addresses cannot occur.
- Reset mid-operation: all state clears immediately, pending busy bits are lost, and any write on the reset edge is discarded.

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data combinationally.
  - If rd_addr[k] == wr0_addr && wr0_en, rd_data[k] = wr0_data; else if it matches wr1_addr with wr1_en, rd_data[k] = wr1_data.
  - Same-address dual write forwards wr0, consistent with commit priority.
  - A match with wr1 forces rd_busy[k] = 0.
- Undefined: reads return stored contents only, with the one-cycle visibility described above.

Test Plan (WIDTH=8, DEPTH=4, RD_PORTS=2, macro undefined unless stated):
- Reset then write 0xAA..0xDD into r0..r3 via wr0, one per cycle; rd_addr={3,0} -> rd_data port1=0xDD, port0=0xAA; rd_addr={2,1} -> 0xCC, 0xBB.
- Same edge: wr0 r2=0x11 and wr1 r2=0x22 -> r2 reads 0x11; wr_conflict=1 for exactly one cycle, then 0.
- iss_en r1 -> rd_busy=1 for r1. iss_en r1 again -> iss_stall=1. wr1 r1=0x55 -> busy=0, r1=0x55, iss_stall=0.
- With r3 busy: iss_en r3 and wr1 r3=0x77 on the same edge -> r3=0x77, busy stays 1; iss_stall=1 during that cycle.
- Assert rst mid-stream with r0=0xAA and r1 busy -> immediately rd_data=0 and rd_busy=0, before any clock edge.
- REG_BYPASS_EN defined: wr0 r0=0x99 with rd_addr port0=0 -> rd_data=0x99 in the same cycle. Undefined: old value until after the edge.
